// File: rtl/rv_fetch_pkg.sv
// Shared constants and the buffered-instruction record for the fetch buffer.
package rv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;
  localparam int          FETCH_ADDR_W     = 32;
  localparam int          FETCH_DATA_W     = 32;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instructions; flush empties it in one cycle.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  entry_t               push_data,
  output entry_t               head,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/rv_fetch_buffer.sv
// Instruction prefetch buffer: sequential imem fetches into a small FIFO,
// presented to decode with valid/ready and flushed on execute-stage redirects.
module rv_fetch_buffer
  import rv_fetch_pkg::*;
#(
  parameter int                    WIDTH_ADDR      = 32,
  parameter int                    WIDTH_DATA      = 32,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [WIDTH_ADDR-1:0] RESET_PC        = WIDTH_ADDR'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [WIDTH_ADDR-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [WIDTH_ADDR-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WIDTH_DATA-1:0] imem_rdata,
  output logic                  out_valid,
  output logic [WIDTH_DATA-1:0] out_instr,
  output logic [WIDTH_ADDR-1:0] out_pc,
  output logic [WIDTH_ADDR-1:0] out_pc_plus4,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WIDTH_ADDR-1:0] STEP       = WIDTH_ADDR'(INSTR_BYTES);
  localparam logic [WIDTH_ADDR-1:0] ALIGN_MASK = ~WIDTH_ADDR'(INSTR_BYTES - 1);

  logic                  req_q,         req_d;
  logic [WIDTH_ADDR-1:0] addr_q,        addr_d;
  logic [WIDTH_ADDR-1:0] fetch_pc_q,    fetch_pc_d;
  logic [WIDTH_ADDR-1:0] resp_pc_q,     resp_pc_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [OUT_W-1:0]      discard_q,     discard_d;
  logic                  stale_q,       stale_d;

  logic                  grant;
  logic [WIDTH_ADDR-1:0] redirect_aligned;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      fifo_count_d;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q         <= 1'b0;
      addr_q        <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      stale_q       <= 1'b0;
    end else begin
      req_q         <= req_d;
      addr_q        <= addr_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      stale_q       <= stale_d;
    end
  end

  always_comb begin
    grant            = req_q && imem_gnt;
    redirect_aligned = redirect_pc & ALIGN_MASK;
    fifo_flush       = redirect_valid;
    fifo_pop         = !fifo_empty && out_ready && !redirect_valid;
    fifo_push        = imem_rvalid && !redirect_valid && (discard_q == '0)
                       && (!fifo_full || fifo_pop);

    outstanding_d = outstanding_q + OUT_W'(grant) - OUT_W'(imem_rvalid);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    stale_d       = stale_q;

    if (redirect_valid) begin
      // Everything granted so far belongs to the old path; a request still
      // waiting for grant keeps its address and is discarded once granted.
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      discard_d  = outstanding_d;
      stale_d    = req_q && !imem_gnt;
    end else begin
      if (grant) begin
        if (stale_q) begin
          stale_d = 1'b0;
        end else begin
          fetch_pc_d = fetch_pc_q + STEP;
        end
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - OUT_W'(1);
      end
      if (grant && stale_q) begin
        discard_d = discard_d + OUT_W'(1);
      end
      if (fifo_push) begin
        resp_pc_d = resp_pc_q + STEP;
      end
    end

    if (fifo_flush) begin
      fifo_count_d = '0;
    end else begin
      fifo_count_d = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    // A request stays up with a fixed address until granted.
    if (req_q && !imem_gnt) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = ((int'(fifo_count_d) + int'(outstanding_d)) < DEPTH)
               && (int'(outstanding_d) < MAX_OUTSTANDING);
      addr_d = fetch_pc_d;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.instr = imem_rdata;
    push_entry.pc    = resp_pc_q;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .push_data (push_entry),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign out_valid    = !fifo_empty;
  assign out_instr    = out_valid ? head_entry.instr : '0;
  assign out_pc       = out_valid ? head_entry.pc : '0;
  assign out_pc_plus4 = out_valid ? (head_entry.pc + STEP) : '0;

endmodule

// File: tb/tb_rv_fetch_buffer.sv
// Bench for rv_fetch_buffer: hand-derived vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_rv_fetch_buffer;
  import rv_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  rv_fetch_buffer #(
    .WIDTH_ADDR      (32),
    .WIDTH_DATA      (32),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_ready      (out_ready)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          rdy;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  mreq_t       memq[$];
  ent_t        mq[$];
  bit          exp_req;
  logic [31:0] exp_addr;
  logic [31:0] mpc;
  bit          pend_stale;
  int          cyc;
  int          pops;
  int          checks;
  int          failures;
  vec_t        vecs[16];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_idle();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic model_reset();
    memq.delete();
    mq.delete();
    exp_req    = 1'b0;
    exp_addr   = 32'h0;
    mpc        = 32'h0;
    pend_stale = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
      chk("out_pc_plus4", out_pc_plus4, mq[0].pc + 32'd4);
    end
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
  endtask

  // One cycle, entered and left at a falling edge: check, drive, advance model.
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input int resp_pct, input int lat);
    bit          rv;
    bit          grant;
    logic [31:0] rdata;
    mreq_t       e;
    mreq_t       nr;
    ent_t        ne;
    check_outputs();
    rv    = 1'b0;
    rdata = '0;
    if (memq.size() != 0 && memq[0].rdy <= cyc && int'($urandom_range(99)) < resp_pct) begin
      rv    = 1'b1;
      rdata = mem_data(memq[0].addr);
    end
    imem_gnt       = gnt;
    imem_rvalid    = rv;
    imem_rdata     = rdata;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    grant = exp_req && gnt;
    if (!redir && rdy && mq.size() != 0) begin
      ne = mq.pop_front();
      pops++;
    end
    if (rv) begin
      e = memq.pop_front();
      if (!redir && !e.stale) begin
        ne.pc    = e.addr;
        ne.instr = rdata;
        mq.push_back(ne);
      end
    end
    if (grant) begin
      nr.addr  = exp_addr;
      nr.stale = pend_stale;
      nr.rdy   = cyc + lat;
      memq.push_back(nr);
      if (!pend_stale) mpc = mpc + 32'd4;
      pend_stale = 1'b0;
    end
    if (redir) begin
      mq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      mpc = {rpc[31:2], 2'b00};
      if (exp_req && !gnt) pend_stale = 1'b1;
    end
    if (!(exp_req && !gnt)) begin
      exp_req  = ((mq.size() + memq.size()) < DEPTH) && (memq.size() < MAXO);
      exp_addr = mpc;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    bit          seen;
    logic [31:0] rpc;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    pops     = 0;

    // rst, gnt, rv, rdata, rdy, redir, rpc | req, addr, valid, pc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'hA5A5_0000, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'hA5A5_0004, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'hA5A5_0008, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'hA5A5_000C, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h202, 1'b1, 32'h10,  1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hA5A5_0010, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'hA5A5_0200, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'hA5A5_0204, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 32'hA5A5_0100, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};

    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc_plus4", out_pc_plus4, 32'h0);

    for (int i = 0; i < 16; i++) begin
      rst_n          = vecs[i].rst;
      imem_gnt       = vecs[i].gnt;
      imem_rvalid    = vecs[i].rv;
      imem_rdata     = vecs[i].rdata;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      cyc++;
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), out_instr, mem_data(vecs[i].e_pc));
        chk($sformatf("vec%0d_pc_plus4", i), out_pc_plus4, vecs[i].e_pc + 32'd4);
      end
    end

    // Streaming: one instruction per cycle once the pipe is primed.
    apply_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 100, 1);
    pops = 0;
    repeat (16) step(1'b1, 1'b1, 1'b0, 32'h0, 100, 1);
    chk("stream_throughput", 32'(pops), 32'd16);

    // Backpressure: fill, stop requesting, then drain in order.
    apply_reset();
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0, 100, 1);
    chk("bp_req_stopped", 32'(imem_req), 32'h0);
    chk("bp_head_pc", out_pc, 32'h0);
    repeat (16) step(1'b1, 1'b1, 1'b0, 32'h0, 100, 1);

    // Redirect with two granted-but-unanswered requests.
    apply_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 0, 1);
    step(1'b1, 1'b1, 1'b1, 32'h100, 0, 1);
    chk("redir_valid_drop", 32'(out_valid), 32'h0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      if (out_valid) seen = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0, 100, 1);
      n++;
    end
    chk("redir_first_seen", 32'(seen), 32'h1);
    chk("redir_first_pc", out_pc, 32'h100);
    chk("redir_first_instr", out_instr, mem_data(32'h100));
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 100, 1);

    // Reset mid-stream clears the outputs without waiting for a clock edge.
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 100, 1);
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_req", 32'(imem_req), 32'h0);
    model_reset();
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 100, 1);

    // Randomized traffic with stalls, latency, redirects and address wrap.
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : ($urandom() & 32'h0000_0FFF);
      step($urandom_range(99) < 70, $urandom_range(99) < 70, $urandom_range(99) < 5,
           rpc, 70, int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
